// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and the ROM.
// The ROM answers combinationally within the same cycle.
interface fetch_stage_if #(
  parameter int unsigned A_WIDTH = 32
);
  logic [A_WIDTH-1:0] imem_addr_o;
  logic [31:0]        imem_rd_i;

  modport master (
    output imem_addr_o,
    input  imem_rd_i
  );

  modport slave (
    input  imem_addr_o,
    output imem_rd_i
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC register, ROM addressing, IF/ID register.
// Handles stall, redirect, flush, misaligned targets, ROM window.
module fetch_stage #(
  parameter int unsigned        A_WIDTH      = 32,
  parameter logic [A_WIDTH-1:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [A_WIDTH-1:0] ROM_LAST     = 32'hBFC00FFF,
  parameter logic [31:0]        NOP_INSTR    = 32'h00000013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [A_WIDTH-1:0] target_i,
  input  logic               flush_i,
  fetch_stage_if.master      imem,
  output logic [31:0]        instr_d_o,
  output logic [A_WIDTH-1:0] pc_d_o,
  output logic [A_WIDTH-1:0] pc_plus4_d_o,
  output logic               valid_d_o,
  output logic               fetch_fault_o,
  output logic               misalign_o
);

  logic [A_WIDTH-1:0] pc_q;
  logic [A_WIDTH-1:0] pc_plus4;
  logic [A_WIDTH:0]   pc_end;
  logic               in_range;
  logic               bubble;

  assign imem.imem_addr_o = pc_q;
  assign pc_plus4 = pc_q + A_WIDTH'(4);

  // Last byte of the word, one bit wider so it cannot wrap.
  assign pc_end = {1'b0, pc_q} + (A_WIDTH+1)'(3);

  assign in_range = (pc_q >= RESET_VECTOR) &&
                    (pc_end <= {1'b0, ROM_LAST});

  assign bubble = flush_i || redirect_i;

  // PC: redirect beats stall, otherwise step by one word.
  always_ff @(posedge clk) begin
    if (rst)
      pc_q <= RESET_VECTOR;
    else if (redirect_i)
      pc_q <= {target_i[A_WIDTH-1:2], 2'b00};
    else if (!stall_i)
      pc_q <= pc_plus4;
  end

  // IF/ID: bubble on flush/redirect, hold on stall, else capture.
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      instr_d_o     <= NOP_INSTR;
      pc_d_o        <= '0;
      pc_plus4_d_o  <= '0;
      valid_d_o     <= 1'b0;
      fetch_fault_o <= 1'b0;
    end else if (!stall_i) begin
      pc_d_o        <= pc_q;
      pc_plus4_d_o  <= pc_plus4;
      instr_d_o     <= in_range ? imem.imem_rd_i : NOP_INSTR;
      valid_d_o     <= in_range;
      fetch_fault_o <= !in_range;
    end
  end

  // One-cycle flag for a redirect target with low bits set.
  always_ff @(posedge clk) begin
    if (rst)
      misalign_o <= 1'b0;
    else
      misalign_o <= redirect_i && (target_i[1:0] != 2'b00);
  end

endmodule
